// File: rtl/shifter_pkg.sv
// Shared encodings for the 8-bit shifter stage and the sequencer that drives it.
package shifter_pkg;
    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LSL  = 3'b010;
    localparam logic [2:0] SH_LSR  = 3'b011;
    localparam logic [2:0] SH_ASR  = 3'b100;

    typedef enum logic [1:0] {
        REQ_LSL  = 2'b00,
        REQ_LSR  = 2'b01,
        REQ_ASR  = 2'b10,
        REQ_LOAD = 2'b11
    } req_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_RESP
    } state_e;

    function automatic logic [2:0] map_shift_op(req_op_e op);
        case (op)
            REQ_LSL: return SH_LSL;
            REQ_LSR: return SH_LSR;
            REQ_ASR: return SH_ASR;
            default: return SH_NOP;
        endcase
    endfunction
endpackage

// File: rtl/shamt_split.sv
// Splits the remaining shift amount into a 2-bit-limited step (greedy, 3 first).
module shamt_split (
    input  logic [2:0] rem,
    output logic [1:0] step,
    output logic [2:0] rem_next
);
    assign step     = (rem > 3'd3) ? 2'd3 : rem[1:0];
    assign rem_next = rem - {1'b0, step};
endmodule

// File: rtl/shift_seq.sv
// Sequences one shift request into LOAD + shift steps on the 8-bit shifter,
// then hands the shifter output back over a valid/ready response.
module shift_seq
    import shifter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_amt,
    input  logic [7:0] req_data,
    output logic [2:0] sh_op,
    output logic [1:0] sh_shamt,
    output logic [7:0] sh_d_in,
    input  logic [7:0] sh_d_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy
);
    state_e     state_q, state_d;
    req_op_e    op_q;
    logic [2:0] rem_q;
    logic [7:0] data_q;
    logic [1:0] step;
    logic [2:0] rem_next;

    shamt_split u_split (
        .rem      (rem_q),
        .step     (step),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= REQ_LSL;
            rem_q   <= 3'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                op_q   <= req_op_e'(req_op);
                rem_q  <= req_amt;
                data_q <= req_data;
            end else if (state_q == ST_SHIFT) begin
                rem_q <= rem_next;
            end
        end
    end

    // Outputs decode only from registered state so req_* never reaches sh_*.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        sh_op     = SH_NOP;
        sh_shamt  = 2'd0;
        sh_d_in   = 8'd0;
        rsp_valid = 1'b0;
        rsp_data  = 8'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sh_op   = SH_LOAD;
                sh_d_in = data_q;
                state_d = (rem_q != 3'd0 && op_q != REQ_LOAD) ? ST_SHIFT : ST_RESP;
            end
            ST_SHIFT: begin
                sh_op    = map_shift_op(op_q);
                sh_shamt = step;
                if (rem_next == 3'd0) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = sh_d_out;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
